nibble_gather_ctrl: RTL and testbench

Sequencer and two-port arbiter for the four-lane nibble selector datapath (`selector4`). It accepts gather requests from two requesters, each carrying an 8-entry nibble map. It drives the selector's lane selects over two passes and reassembles the registered 16-bit selector output into one 32-bit result word. The result is returned under a valid/ready handshake. DATA_A/DATA_B feed the selector directly; this block never sees them.

---
 rtl/nibble_gather_ctrl.sv | 127 ++++++++++++
 tb/tb_nibble_gather_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_gather_ctrl.sv
// Two-requester gather sequencer for the selector4 datapath: drives lane selects
// over two passes and reassembles the registered nibble output into a 32-bit word.
module nibble_gather_ctrl (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_map0,
    input  logic [31:0] req_map1,
    output logic [11:0] sl_sel_A,
    output logic [11:0] sl_sel_B,
    output logic [3:0]  sl_SEL,
    input  logic [15:0] NIBBLE_OUT,
    output logic [31:0] out_word,
    output logic        out_id,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned LANES   = 4;
    localparam int unsigned ENTRY_W = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HALF_W  = LANES * ENTRY_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         map_q;
    logic                id_q;
    logic                rr_q;
    logic                gnt_c;
    logic                hs_c;
    logic [HALF_W-1:0]   half_c;

    // Both requesting: round-robin pointer decides; otherwise the lone requester wins.
    assign gnt_c = (req_valid == 2'b11) ? rr_q : req_valid[1];
    assign hs_c  = (state_q == IDLE) && (|req_valid);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        busy      = 1'b1;
        out_valid = 1'b0;
        half_c    = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    req_ready = gnt_c ? 2'b10 : 2'b01;
                    state_d   = LO;
                end
            end
            LO: begin
                half_c  = map_q[HALF_W-1:0];
                state_d = HI;
            end
            HI: begin
                half_c  = map_q[2*HALF_W-1:HALF_W];
                state_d = CAP;
            end
            CAP: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane selects are a pure decode of the active map half; zero outside LO/HI.
    always_comb begin
        sl_SEL   = '0;
        sl_sel_A = '0;
        sl_sel_B = '0;
        for (int i = 0; i < LANES; i++) begin
            sl_SEL[i]                = half_c[ENTRY_W*i + IDX_W];
            sl_sel_A[IDX_W*i +: IDX_W] = half_c[ENTRY_W*i +: IDX_W];
            sl_sel_B[IDX_W*i +: IDX_W] = half_c[ENTRY_W*i +: IDX_W];
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            map_q    <= '0;
            id_q     <= 1'b0;
            rr_q     <= 1'b0;
            out_word <= '0;
            out_id   <= 1'b0;
        end else begin
            if (hs_c) begin
                map_q <= gnt_c ? req_map1 : req_map0;
                id_q  <= gnt_c;
                rr_q  <= ~gnt_c;
            end
            // Selector output lags selects by one cycle: LO data lands in HI, HI data in CAP.
            if (state_q == HI) begin
                out_word[HALF_W-1:0] <= NIBBLE_OUT;
            end
            if (state_q == CAP) begin
                out_word[2*HALF_W-1:HALF_W] <= NIBBLE_OUT;
                out_id                      <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_nibble_gather_ctrl.sv
// Bench for nibble_gather_ctrl: registered selector4 model plus a spec-level
// gather/arbitration reference, directed cases followed by randomized traffic.
module tb_nibble_gather_ctrl;

    logic        CLK;
    logic        RESET_L;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_map0;
    logic [31:0] req_map1;
    logic [11:0] sl_sel_A;
    logic [11:0] sl_sel_B;
    logic [3:0]  sl_SEL;
    logic [15:0] NIBBLE_OUT;
    logic [31:0] out_word;
    logic        out_id;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        model_rr;
    int          checks;
    int          failures;

    nibble_gather_ctrl dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_map0   (req_map0),
        .req_map1   (req_map1),
        .sl_sel_A   (sl_sel_A),
        .sl_sel_B   (sl_sel_B),
        .sl_SEL     (sl_SEL),
        .NIBBLE_OUT (NIBBLE_OUT),
        .out_word   (out_word),
        .out_id     (out_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] nib_of(input logic [31:0] d, input logic [2:0] idx);
        logic [31:0] s;
        s = d >> {idx, 2'b00};
        return s[3:0];
    endfunction

    // selector4 environment model: one registered nibble per lane.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            NIBBLE_OUT <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                NIBBLE_OUT[4*i +: 4] <= sl_SEL[i] ? nib_of(data_b, sl_sel_B[3*i +: 3])
                                                  : nib_of(data_a, sl_sel_A[3*i +: 3]);
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] m, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] w;
        logic [3:0]  e;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            e = 4'((m >> (4*k)) & 32'hF);
            w = w | (32'(e[3] ? nib_of(b, e[2:0]) : nib_of(a, e[2:0])) << (4*k));
        end
        return w;
    endfunction

    // Expected {sl_SEL, sl_sel_A, sl_sel_B} when the four given entries drive lanes 0..3.
    function automatic logic [27:0] exp_sel(input logic [15:0] h);
        logic [3:0]  s;
        logic [11:0] ix;
        logic [3:0]  e;
        s  = '0;
        ix = '0;
        for (int i = 0; i < 4; i++) begin
            e  = 4'((h >> (4*i)) & 16'hF);
            s  = s | (4'(e[3]) << i);
            ix = ix | (12'(e[2:0]) << (3*i));
        end
        return {s, ix, ix};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_L   = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        model_rr  = 1'b0;
        #1;
        chk("rst_word", out_word, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_sel", 32'({sl_SEL, sl_sel_A, sl_sel_B}), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // One complete gather; called 1 time unit after a posedge with the DUT in IDLE.
    task automatic gather(input logic [1:0] vld, input int bp);
        logic        g;
        logic [1:0]  rdy;
        logic [31:0] m;
        logic [31:0] w;
        g   = (vld == 2'b11) ? model_rr : vld[1];
        rdy = g ? 2'b10 : 2'b01;
        m   = g ? req_map1 : req_map0;
        w   = exp_word(m, data_a, data_b);
        req_valid = vld;
        out_ready = (bp == 0);
        #1;
        chk("idle_busy", 32'(busy), 32'h0);
        chk("req_ready", 32'(req_ready), 32'(rdy));
        @(posedge CLK);
        model_rr = ~g;
        #1;
        if (vld != 2'b11) req_valid = 2'b00;
        chk("lo_busy", 32'(busy), 32'h1);
        chk("lo_ready", 32'(req_ready), 32'h0);
        chk("lo_sel", 32'({sl_SEL, sl_sel_A, sl_sel_B}), 32'(exp_sel(m[15:0])));
        @(posedge CLK);
        #1;
        chk("hi_sel", 32'({sl_SEL, sl_sel_A, sl_sel_B}), 32'(exp_sel(m[31:16])));
        chk("hi_valid", 32'(out_valid), 32'h0);
        @(posedge CLK);
        #1;
        chk("cap_sel", 32'({sl_SEL, sl_sel_A, sl_sel_B}), 32'h0);
        chk("cap_valid", 32'(out_valid), 32'h0);
        @(posedge CLK);
        #1;
        chk("valid_latency", 32'(out_valid), 32'h1);
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge CLK);
            #1;
        end
        chk("out_word", out_word, w);
        chk("out_id", 32'(out_id), 32'(g));
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_word", out_word, w);
            chk("bp_busy", 32'(busy), 32'h1);
            chk("bp_ready", 32'(req_ready), 32'h0);
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_busy", 32'(busy), 32'h0);
        chk("post_valid", 32'(out_valid), 32'h0);
        chk("hold_word", out_word, w);
        chk("hold_id", 32'(out_id), 32'(g));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        req_map0  = '0;
        req_map1  = '0;
        data_a    = '0;
        data_b    = '0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        model_rr  = 1'b0;
        RESET_L   = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // identity gather
        data_a   = 32'h76543210;
        req_map0 = 32'h76543210;
        gather(2'b01, 0);
        chk("identity_word", out_word, 32'h76543210);

        // mixed and reversed sources from requester 1
        data_a   = 32'h89ABCDEF;
        data_b   = 32'h01234567;
        req_map1 = 32'h89AB0123;
        gather(2'b10, 0);
        chk("mixed_word", out_word, 32'h7654FEDC);

        // broadcast
        data_a   = 32'h0000A000;
        req_map0 = 32'h33333333;
        gather(2'b01, 0);
        chk("broadcast_word", out_word, 32'hAAAAAAAA);

        // arbitration under continuous dual requests
        do_reset();
        data_a   = 32'hFEDCBA98;
        data_b   = 32'h13579BDF;
        req_map0 = 32'h01234567;
        req_map1 = 32'h89ABCDEF;
        for (int n = 0; n < 4; n++) begin
            gather(2'b11, 0);
            chk("arb_order", 32'(out_id), 32'(n % 2));
        end
        req_valid = 2'b00;

        // backpressure
        gather(2'b01, 10);

        // reset during HI discards the gather
        req_map0  = 32'hFEDCBA98;
        req_valid = 2'b01;
        @(posedge CLK);
        #1;
        req_valid = 2'b00;
        @(posedge CLK);
        #1;
        RESET_L = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_sel", 32'({sl_SEL, sl_sel_A, sl_sel_B}), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_word", out_word, 32'h0);
        model_rr = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        gather(2'b01, 0);

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            logic [1:0] v;
            data_a   = $urandom;
            data_b   = $urandom;
            req_map0 = $urandom;
            req_map1 = $urandom;
            v        = 2'($urandom_range(1, 3));
            gather(v, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
